// File: rtl/cv32e40x_clock_en_ctrl.sv
// ----------------------------------------------------------------------------
// cv32e40x_clock_en_ctrl
//
// Sleep / clock-enable controller running on the free-running clock. It
// counts in-flight instruction and data OBI transactions. After a WFI request
// it drains them and then drops the enable of the downstream core clock gate.
// On a wake request it raises the enable again, and it keeps core_sleep_o
// asserted for WAKE_DELAY more cycles so the core clock can settle.
//
// Parameters
//   MAX_OUTSTANDING  maximum in-flight transactions per OBI interface
//   WAKE_DELAY       cycles clock_en_o is high before core_sleep_o drops (0..15)
//
// Ports
//   clk_ungated_i   free-running clock
//   rst_n           asynchronous active-low reset
//   fetch_enable_i  boot enable (made sticky on fetch_enable_o)
//   wfi_req_i       sleep request from the controller (level)
//   wake_req_i      pending interrupt / debug request (level)
//   instr_*_i       instruction OBI req / gnt / rvalid
//   data_*_i        data OBI req / gnt / rvalid
//   clock_en_o      registered enable for the core clock gate
//   core_sleep_o    core asleep or still waking
//   fetch_enable_o  sticky copy of fetch_enable_i
//   instr_cnt_o     outstanding instruction transactions
//   data_cnt_o      outstanding data transactions
//   obi_err_o       sticky OBI protocol-violation flag
// ----------------------------------------------------------------------------
module cv32e40x_clock_en_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned WAKE_DELAY      = 1,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_ungated_i,
  input  logic             rst_n,
  input  logic             fetch_enable_i,
  input  logic             wfi_req_i,
  input  logic             wake_req_i,
  input  logic             instr_req_i,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  input  logic             data_req_i,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  output logic             clock_en_o,
  output logic             core_sleep_o,
  output logic             fetch_enable_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] data_cnt_o,
  output logic             obi_err_o
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [3:0]       WAKE_LOAD  = 4'(WAKE_DELAY);

  state_e           state_reg, state_next;
  logic [3:0]       wake_cnt_reg, wake_cnt_next;
  logic             clock_en_reg, clock_en_next;
  logic             core_sleep_reg, core_sleep_next;
  logic             fetch_enable_reg;
  logic             err_reg, err_next;

  // Index 0 = instruction interface, index 1 = data interface.
  logic [1:0]       inc, dec, ovf, unf;
  logic [CNT_W-1:0] cnt_reg  [2];
  logic [CNT_W-1:0] cnt_next [2];
  logic             drained;

  assign inc = {data_req_i & data_gnt_i, instr_req_i & instr_gnt_i};
  assign dec = {data_rvalid_i, instr_rvalid_i};

  // Outstanding-transaction counters. A simultaneous grant and response
  // cancel out. Over- and underflow hold the count and raise an error.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] nxt;
      logic             o_flag, u_flag;

      always_comb begin
        nxt    = cnt_reg[gi];
        o_flag = 1'b0;
        u_flag = 1'b0;
        if (inc[gi] && !dec[gi]) begin
          if (cnt_reg[gi] == CNT_MAX) o_flag = 1'b1;
          else                        nxt = cnt_reg[gi] + CNT_W'(1);
        end else if (dec[gi] && !inc[gi]) begin
          if (cnt_reg[gi] == '0) u_flag = 1'b1;
          else                   nxt = cnt_reg[gi] - CNT_W'(1);
        end
      end

      assign cnt_next[gi] = nxt;
      assign ovf[gi]      = o_flag;
      assign unf[gi]      = u_flag;

      always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) cnt_reg[gi] <= '0;
        else        cnt_reg[gi] <= nxt;
      end
    end
  endgenerate

  // Sleep is allowed only when nothing is in flight after this cycle's update
  // and no new request is being presented.
  assign drained = (cnt_next[0] == '0) && (cnt_next[1] == '0) &&
                   !instr_req_i && !data_req_i;

  // A grant while the clock is off is a protocol violation.
  assign err_next = err_reg | (|ovf) | (|unf) | ((state_reg == SLEEP) && (|inc));

  // State register
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= BOOT;
      wake_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wake_cnt_reg <= wake_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    wake_cnt_next = wake_cnt_reg;
    case (state_reg)
      BOOT:  if (fetch_enable_i) state_next = RUN;
      RUN:   if (wfi_req_i && !wake_req_i) state_next = DRAIN;
      DRAIN: begin
        // Wake has priority over a drain completing in the same cycle.
        if (wake_req_i || !wfi_req_i) state_next = RUN;
        else if (drained)             state_next = SLEEP;
      end
      SLEEP: begin
        if (wake_req_i) begin
          if (WAKE_DELAY == 0) begin
            state_next = RUN;
          end else begin
            state_next    = WAKE;
            wake_cnt_next = WAKE_LOAD;
          end
        end
      end
      WAKE: begin
        // WAKE lasts exactly WAKE_DELAY cycles. A dropped wake_req_i does not
        // abort it.
        wake_cnt_next = (wake_cnt_reg == 4'd0) ? 4'd0 : wake_cnt_reg - 4'd1;
        if (wake_cnt_reg <= 4'd1) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  // Output decode from the next state. The result is registered, so the gate
  // enable has no combinational path from any input.
  always_comb begin
    clock_en_next   = 1'b0;
    core_sleep_next = 1'b0;
    case (state_next)
      RUN, DRAIN: clock_en_next = 1'b1;
      WAKE: begin
        clock_en_next   = 1'b1;
        core_sleep_next = 1'b1;
      end
      SLEEP:   core_sleep_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      clock_en_reg     <= 1'b0;
      core_sleep_reg   <= 1'b0;
      fetch_enable_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      clock_en_reg     <= clock_en_next;
      core_sleep_reg   <= core_sleep_next;
      fetch_enable_reg <= fetch_enable_reg | fetch_enable_i;
      err_reg          <= err_next;
    end
  end

  assign clock_en_o     = clock_en_reg;
  assign core_sleep_o   = core_sleep_reg;
  assign fetch_enable_o = fetch_enable_reg;
  assign instr_cnt_o    = cnt_reg[0];
  assign data_cnt_o     = cnt_reg[1];
  assign obi_err_o      = err_reg;

endmodule

// File: tb/tb_cv32e40x_clock_en_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for cv32e40x_clock_en_ctrl (MAX_OUTSTANDING=2, WAKE_DELAY=3).
// It runs in three parts:
//   1. A table of single-cycle vectors with expected outputs written by hand.
//   2. Hand-written sequences for boot, a grant while asleep, and async reset.
//   3. Random stimulus checked each cycle against a behavioural model.
// ----------------------------------------------------------------------------
module tb_cv32e40x_clock_en_ctrl;

  localparam int MAX   = 2;
  localparam int WD    = 3;
  localparam int CNT_W = $clog2(MAX + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fe = 1'b0, wfi = 1'b0, wake = 1'b0;
  logic ireq = 1'b0, ignt = 1'b0, irv = 1'b0;
  logic dreq = 1'b0, dgnt = 1'b0, drv = 1'b0;
  logic ce, sl, feo, err;
  logic [CNT_W-1:0] icnt, dcnt;

  cv32e40x_clock_en_ctrl #(.MAX_OUTSTANDING(MAX), .WAKE_DELAY(WD)) dut (
    .clk_ungated_i (clk),
    .rst_n         (rst_n),
    .fetch_enable_i(fe),
    .wfi_req_i     (wfi),
    .wake_req_i    (wake),
    .instr_req_i   (ireq),
    .instr_gnt_i   (ignt),
    .instr_rvalid_i(irv),
    .data_req_i    (dreq),
    .data_gnt_i    (dgnt),
    .data_rvalid_i (drv),
    .clock_en_o    (ce),
    .core_sleep_o  (sl),
    .fetch_enable_o(feo),
    .instr_cnt_o   (icnt),
    .data_cnt_o    (dcnt),
    .obi_err_o     (err)
  );

  always #5 clk = ~clk;

  int vec_count = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: a power mode, a settle countdown and two counts.
  // ------------------------------------------------------------------------
  localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_SLEEP = 3, M_WAKE = 4;
  int m_mode, m_icnt, m_dcnt, m_wake_left;
  bit m_fe, m_err;

  function automatic void count_update(inout int cnt, input bit up, input bit down, inout bit e);
    int n;
    n = cnt + int'(up) - int'(down);
    if (n > MAX || n < 0) e = 1'b1;
    else cnt = n;
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT; m_icnt = 0; m_dcnt = 0; m_wake_left = 0;
    m_fe = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit gi_, gd_, e;
    gi_ = ireq & ignt;
    gd_ = dreq & dgnt;
    e = m_err;
    if (m_mode == M_SLEEP && (gi_ || gd_)) e = 1'b1;
    count_update(m_icnt, gi_, irv, e);
    count_update(m_dcnt, gd_, drv, e);
    m_err = e;
    if (fe) m_fe = 1'b1;
    case (m_mode)
      M_BOOT:  if (fe) m_mode = M_RUN;
      M_RUN:   if (wfi && !wake) m_mode = M_DRAIN;
      M_DRAIN: begin
        if (wake || !wfi) m_mode = M_RUN;
        else if (m_icnt + m_dcnt == 0 && !ireq && !dreq) m_mode = M_SLEEP;
      end
      M_SLEEP: if (wake) begin
        if (WD == 0) m_mode = M_RUN;
        else begin m_mode = M_WAKE; m_wake_left = WD; end
      end
      M_WAKE: begin
        m_wake_left--;
        if (m_wake_left == 0) m_mode = M_RUN;
      end
      default: m_mode = M_BOOT;
    endcase
  endtask

  task automatic check_all(input string tag);
    bit exp_ce, exp_sl;
    exp_ce = (m_mode == M_RUN) || (m_mode == M_DRAIN) || (m_mode == M_WAKE);
    exp_sl = (m_mode == M_SLEEP) || (m_mode == M_WAKE);
    check({tag, ".clock_en"}, 32'(ce), 32'(exp_ce));
    check({tag, ".core_sleep"}, 32'(sl), 32'(exp_sl));
    check({tag, ".fetch_en"}, 32'(feo), 32'(m_fe));
    check({tag, ".instr_cnt"}, 32'(icnt), 32'(m_icnt));
    check({tag, ".data_cnt"}, 32'(dcnt), 32'(m_dcnt));
    check({tag, ".obi_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic clear_inputs();
    fe = 0; wfi = 0; wake = 0; ireq = 0; ignt = 0; irv = 0; dreq = 0; dgnt = 0; drv = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------------
  // Vector table
  // ------------------------------------------------------------------------
  typedef struct {
    logic [8:0] in_bits;   // {fe, wfi, wake, ireq, ignt, irv, dreq, dgnt, drv}
    logic ce, sl, fo;
    int   ic, dc;
    logic er;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [8:0] b, input logic c, input logic s,
                              input logic f, input int i, input int d, input logic e);
    vec_t v;
    v.in_bits = b; v.ce = c; v.sl = s; v.fo = f; v.ic = i; v.dc = d; v.er = e;
    return v;
  endfunction

  initial begin
    string tag;
    logic [8:0] b;

    //            fe_wfi wake_ireq ignt irv_dreq dgnt drv   ce sl fo ic dc er
    vecs[0]  = mk(9'b0_00_000_000, 0, 0, 0, 0, 0, 0);  // BOOT
    vecs[1]  = mk(9'b0_00_000_000, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(9'b1_00_000_000, 1, 0, 1, 0, 0, 0);  // -> RUN
    vecs[3]  = mk(9'b0_00_110_000, 1, 0, 1, 1, 0, 0);
    vecs[4]  = mk(9'b0_00_110_110, 1, 0, 1, 2, 1, 0);
    vecs[5]  = mk(9'b0_00_001_110, 1, 0, 1, 1, 2, 0);
    vecs[6]  = mk(9'b0_00_111_000, 1, 0, 1, 1, 2, 0);  // grant+rvalid at 1
    vecs[7]  = mk(9'b0_10_001_000, 1, 0, 1, 0, 2, 0);  // -> DRAIN
    vecs[8]  = mk(9'b0_10_000_001, 1, 0, 1, 0, 1, 0);
    vecs[9]  = mk(9'b0_10_000_001, 0, 1, 1, 0, 0, 0);  // drained -> SLEEP
    vecs[10] = mk(9'b0_10_000_000, 0, 1, 1, 0, 0, 0);
    vecs[11] = mk(9'b0_01_000_000, 1, 1, 1, 0, 0, 0);  // wake -> WAKE
    vecs[12] = mk(9'b0_00_000_000, 1, 1, 1, 0, 0, 0);  // wake dropped
    vecs[13] = mk(9'b0_00_000_000, 1, 1, 1, 0, 0, 0);
    vecs[14] = mk(9'b0_00_000_000, 1, 0, 1, 0, 0, 0);  // RUN at n+4
    vecs[15] = mk(9'b0_11_000_000, 1, 0, 1, 0, 0, 0);  // wfi+wake: stay
    vecs[16] = mk(9'b0_11_000_000, 1, 0, 1, 0, 0, 0);
    vecs[17] = mk(9'b0_10_000_110, 1, 0, 1, 0, 1, 0);  // -> DRAIN
    vecs[18] = mk(9'b0_11_000_001, 1, 0, 1, 0, 0, 0);  // empty+wake -> RUN
    vecs[19] = mk(9'b0_10_000_000, 1, 0, 1, 0, 0, 0);  // -> DRAIN
    vecs[20] = mk(9'b0_00_000_000, 1, 0, 1, 0, 0, 0);  // wfi drop -> RUN
    vecs[21] = mk(9'b0_00_000_001, 1, 0, 1, 0, 0, 1);  // underflow
    vecs[22] = mk(9'b0_00_000_000, 1, 0, 1, 0, 0, 1);  // sticky
    vecs[23] = mk(9'b0_10_000_000, 1, 0, 1, 0, 0, 1);  // -> DRAIN
    vecs[24] = mk(9'b0_10_000_000, 0, 1, 1, 0, 0, 1);  // -> SLEEP
    vecs[25] = mk(9'b0_10_110_000, 0, 1, 1, 1, 0, 1);  // grant in SLEEP
    vecs[26] = mk(9'b0_10_110_000, 0, 1, 1, 2, 0, 1);
    vecs[27] = mk(9'b0_10_110_000, 0, 1, 1, 2, 0, 1);  // overflow holds

    // ---------------- part 1: vector table ----------------
    do_reset();
    check("reset.clock_en", 32'(ce), 0);
    check("reset.core_sleep", 32'(sl), 0);
    check("reset.fetch_en", 32'(feo), 0);
    check("reset.instr_cnt", 32'(icnt), 0);
    check("reset.data_cnt", 32'(dcnt), 0);
    check("reset.obi_err", 32'(err), 0);

    for (int v = 0; v < NV; v++) begin
      b = vecs[v].in_bits;
      {fe, wfi, wake, ireq, ignt, irv, dreq, dgnt, drv} = b;
      tick();
      tag = $sformatf("vec%0d", v);
      check({tag, ".clock_en"}, 32'(ce), 32'(vecs[v].ce));
      check({tag, ".core_sleep"}, 32'(sl), 32'(vecs[v].sl));
      check({tag, ".fetch_en"}, 32'(feo), 32'(vecs[v].fo));
      check({tag, ".instr_cnt"}, 32'(icnt), 32'(vecs[v].ic));
      check({tag, ".data_cnt"}, 32'(dcnt), 32'(vecs[v].dc));
      check({tag, ".obi_err"}, 32'(err), 32'(vecs[v].er));
      $display("vec %0d in=%09b ce=%0b sl=%0b fe=%0b ic=%0d dc=%0d err=%0b",
               v, b, ce, sl, feo, icnt, dcnt, err);
    end

    // ---------------- part 2: directed sequences ----------------
    // Boot: enable stays low while fetch_enable_i is low, then rises one
    // cycle after a single-cycle pulse. The sticky copy holds afterwards.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("boot_wait%0d.clock_en", c), 32'(ce), 0);
      check($sformatf("boot_wait%0d.fetch_en", c), 32'(feo), 0);
    end
    fe = 1; tick(); fe = 0;
    check("boot_pulse.clock_en", 32'(ce), 1);
    check("boot_pulse.fetch_en", 32'(feo), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("boot_after%0d.fetch_en", c), 32'(feo), 1);
      check($sformatf("boot_after%0d.clock_en", c), 32'(ce), 1);
    end
    $display("seq boot done");

    // A grant while asleep sets a fresh error, is counted, and does not wake.
    wfi = 1; tick();                       // DRAIN
    check("drain.clock_en", 32'(ce), 1);
    tick();                                // SLEEP
    check("sleep.clock_en", 32'(ce), 0);
    check("sleep.core_sleep", 32'(sl), 1);
    check("sleep.obi_err", 32'(err), 0);
    dreq = 1; dgnt = 1; tick(); dreq = 0; dgnt = 0;
    check("sleep_gnt.data_cnt", 32'(dcnt), 1);
    check("sleep_gnt.obi_err", 32'(err), 1);
    check("sleep_gnt.clock_en", 32'(ce), 0);
    tick();
    check("sleep_hold.core_sleep", 32'(sl), 1);
    check("sleep_hold.obi_err", 32'(err), 1);
    $display("seq sleep-violation done");

    // Async reset mid-cycle while asleep: outputs clear without a clock edge.
    #3 rst_n = 1'b0; wfi = 0;
    #1;
    check("async_rst.clock_en", 32'(ce), 0);
    check("async_rst.core_sleep", 32'(sl), 0);
    check("async_rst.fetch_en", 32'(feo), 0);
    check("async_rst.data_cnt", 32'(dcnt), 0);
    check("async_rst.instr_cnt", 32'(icnt), 0);
    check("async_rst.obi_err", 32'(err), 0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst%0d.clock_en", c), 32'(ce), 0);
      check($sformatf("post_rst%0d.core_sleep", c), 32'(sl), 0);
    end
    fe = 1; tick(); fe = 0;
    check("post_rst_boot.clock_en", 32'(ce), 1);
    $display("seq async-reset done");

    // ---------------- part 3: random vs model ----------------
    for (int ep = 0; ep < 8; ep++) begin
      int start_miss;
      start_miss = miscompares;
      do_reset();
      check_all($sformatf("ep%0d.reset", ep));
      for (int c = 0; c < 400; c++) begin
        fe   = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) wfi = ~wfi;
        wake = ($urandom_range(0, 11) == 0);
        ireq = ($urandom_range(0, 3) == 0);
        ignt = ireq & ($urandom_range(0, 1) == 1);
        dreq = ($urandom_range(0, 3) == 0);
        dgnt = dreq & ($urandom_range(0, 1) == 1);
        irv  = (m_icnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
        drv  = (m_dcnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
        @(posedge clk);
        model_step();
        #1;
        check_all($sformatf("ep%0d.c%0d", ep, c));
      end
      $display("random episode %0d: 400 cycles, %0d new miscompares", ep, miscompares - start_miss);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/cv32e40x_clock_en_ctrl.md
Name: cv32e40x_clock_en_ctrl

Overview:
Sleep/clock-enable controller that runs on the ungated clock and drives the enable input of the core clock gate. It tracks outstanding instruction and data OBI transactions, drains them after a WFI request, then deasserts the enable. It restores the enable on a wake request, after a programmable settle delay. The block sits directly upstream of the clock gate; clock_en_o connects to the gate's enable input.

Parameters:
MAX_OUTSTANDING, 2, maximum in-flight transactions per OBI interface; counter width CNT_W = $clog2(MAX_OUTSTANDING+1).
WAKE_DELAY, 1, cycles clock_en_o is high before core_sleep_o drops after wake (0..15).

Ports:
clk_ungated_i  in   1      free-running (ungated) clock
rst_n          in   1      asynchronous reset, active-low
fetch_enable_i in   1      boot enable; sampled and made sticky
wfi_req_i      in   1      controller: core at WFI, pipeline empty, sleep requested (level)
wake_req_i     in   1      pending enabled interrupt or debug request (level)
instr_req_i    in   1      instruction OBI request
instr_gnt_i    in   1      instruction OBI grant
instr_rvalid_i in   1      instruction OBI response valid
data_req_i     in   1      data OBI request
data_gnt_i     in   1      data OBI grant
data_rvalid_i  in   1      data OBI response valid
clock_en_o     out  1      registered enable to the clock gate
core_sleep_o   out  1      registered; core is asleep or still waking
fetch_enable_o out  1      sticky registered copy of fetch_enable_i
instr_cnt_o    out  CNT_W  outstanding instruction transactions
data_cnt_o     out  CNT_W  outstanding data transactions
obi_err_o      out  1      sticky protocol-violation flag

Behaviour:
- Reset (rst_n low, async) values: state BOOT, clock_en_o=0, core_sleep_o=0, fetch_enable_o=0, both counters 0, obi_err_o=0, wake counter 0. Reset asserted mid-sleep or mid-drain aborts immediately to these values.
- All outputs are flops clocked on clk_ungated_i. clock_en_o is driven from the registered next-state decode, so it has no combinational path from inputs (glitch-free gate enable).
- fetch_enable_o: set on the first cycle fetch_enable_i=1; held at 1 until reset.
- Counters, per interface: +1 on req&gnt; -1 on rvalid; both in the same cycle leaves the counter unchanged.
  - Increment at MAX_OUTSTANDING: counter holds, obi_err_o set.
  - Decrement at 0: counter holds, obi_err_o set.
  - Counters update in every state.
- FSM: BOOT, RUN, DRAIN, SLEEP, WAKE.
  - BOOT: clock_en_o=0. Goes to RUN on the cycle fetch_enable_i=1; clock_en_o=1 the following cycle.
  - RUN: clock_en_o=1, core_sleep_o=0.
    - wfi_req_i=1 and wake_req_i=0 -> DRAIN.
    - wfi_req_i and wake_req_i both high -> stay in RUN (wake wins).
  - DRAIN: clock_en_o=1.
    - wake_req_i=1 -> RUN.
    - wfi_req_i dropped -> RUN.
    - Both counters 0 after this cycle's update, and instr_req_i=0 and data_req_i=0 -> SLEEP.
  - SLEEP: clock_en_o=0, core_sleep_o=1.
    - wake_req_i=1 -> WAKE, loading the wake counter with WAKE_DELAY.
    - If WAKE_DELAY=0, go directly to RUN instead.
  - WAKE: clock_en_o=1, core_sleep_o=1. Decrement the wake counter each cycle; at 0 -> RUN (core_sleep_o=0 next cycle).
    - wake_req_i dropping during WAKE does not abort the wake.
- Latency:
  - wake_req_i rising in SLEEP at cycle n -> clock_en_o=1 at n+1.
  - core_sleep_o=0 at n+1+WAKE_DELAY.
  - Drain complete at cycle n -> clock_en_o=0 at n+1.
- Counters reaching 0 in the same cycle wake_req_i rises (DRAIN): wake wins, no sleep.
- Transactions issued while in SLEEP are a protocol violation: they are counted, obi_err_o is set, and the state is unaffected.

Test Plan:
- Boot: release rst_n, fetch_enable_i=0 for 5 cycles, then pulse 1 cycle -> clock_en_o=0 throughout the wait, 1 one cycle after the pulse; fetch_enable_o stays 1 after the pulse.
- Drain: in RUN, 2 data transactions granted with no responses, assert wfi_req_i -> stays in DRAIN with data_cnt_o=2; after both rvalids, clock_en_o=0 and core_sleep_o=1 on the next cycle.
- Wake with WAKE_DELAY=3: wake_req_i pulse in SLEEP at cycle n -> clock_en_o=1 at n+1, core_sleep_o=0 at n+4.
- Simultaneous events: wfi_req_i and wake_req_i both high in RUN -> clock_en_o never drops. Counters hit 0 in the same cycle wake_req_i rises -> no SLEEP entry.
- Counter corner: req&gnt and rvalid in the same cycle with count 1 -> count stays 1. rvalid with count 0 -> count stays 0 and obi_err_o=1 (sticky).
- Async reset asserted in SLEEP mid-cycle -> all outputs 0 immediately; on release, stays in BOOT until fetch_enable_i.
